integrator_arb: RTL and testbench
=================================

# integrator_arb

Shared integrate-and-dump engine for `ch` sample streams. A round-robin arbiter grants one requester per cycle into a single adder. The block keeps one signed accumulator and one sample counter per channel. After `len` accepted samples it dumps that channel's sum through a one-entry output register and restarts the channel from zero. It sits between multichannel sample sources (ADC/CIC front ends) and downstream consumers, and replaces a bank of free-running integrators with a windowed, back-pressured scheduler.

## Interface
- `n`, 16, input sample width (signed)
- `m`, 24, accumulator/output width, m ≥ n + clog2(len)
- `ch`, 4, number of requesting channels, 2..16
- `len`, 256, samples per integration window, ≥ 1
- `clk`  in  1  clock, all state updates on posedge
- `clr_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  ch  per-channel sample valid
- `in_data`  in  ch*n  per-channel signed samples, channel i at bits [i*n +: n]
- `in_ready`  out  ch  one-hot-or-zero grant; sample i accepted when in_valid[i] & in_ready[i]
- `out_valid`  out  1  dump result pending
- `out_ready`  in  1  consumer accepts dump
- `out_ch`  out  clog2(ch)  channel index of pending dump
- `out_data`  out  m  signed window sum

## Operation
- Reset (clr_n low at posedge): all accumulators 0, all counters 0, RR pointer 0, out_valid 0, out_ch 0, out_data 0. Reset overrides every other event in the same cycle, including an in-flight window or a pending dump, which is discarded.
- Eligibility of channel i: in_valid[i] is high, and not (counter[i] == len-1 and out_blocked), where out_blocked = out_valid & ~out_ready.
- Grant: the first eligible channel searching from the RR pointer upward, modulo ch. in_ready is combinational from in_valid, the pointer, the counters, out_valid and out_ready. At most one bit is set. in_ready is all zero when no channel is eligible.
- After a grant to channel g, the pointer becomes (g+1) mod ch. The pointer does not move when there is no grant.
- Accept, non-final (counter[g] < len-1):
  - acc[g] <= acc[g] + sign-extended in_data[g], wrapping modulo 2^m.
  - counter[g] increments.
- Accept, final (counter[g] == len-1):
  - out_data <= acc[g] + sample.
  - out_ch <= g, out_valid <= 1.
  - acc[g] <= 0, counter[g] <= 0.
- Output register has two states, EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - FULL → EMPTY on out_ready, unless a final accept occurs in the same cycle. In that case it stays FULL with the new result loaded (pass-through).
  - EMPTY → FULL on a final accept.
- Non-final accepts proceed regardless of output state. Only the completing sample of a window is back-pressured.
- When len = 1, every accept is final.

## Timing
- Accept-to-accumulator update: 1 cycle (visible at the next posedge).
- Final accept to out_valid high: 1 cycle. out_data and out_ch are stable while out_valid is high and out_ready is low.
- Sustained throughput: one sample per cycle aggregate across channels. One dump per cycle is possible when out_ready is held high.
- No combinational path from out_data to any input. The out_ready → in_ready path is combinational and documented for integrators of this block.

## Configuration
- `INTEGRATOR_ARB_SAT_EN`:
  - Defined: accumulator and dump additions saturate to [-2^(m-1), 2^(m-1)-1] instead of wrapping. Saturation is sticky within a window only; it clears at the dump.
  - Undefined: two's-complement wrap modulo 2^m, with no extra logic.

## Test plan
- Reset: drive clr_n low for 2 cycles with all in_valid high. Required: in_ready 0, out_valid 0, out_data 0 during reset. The first grant after release is to channel 0.
- Round-robin: ch=4, all in_valid high, len=256. Required: grants cycle 0,1,2,3,0,… with no channel skipped. If in_valid[1] is low, the sequence is 0,2,3,0.
- Window sum: len=4, channel 2 alone sends 5, -3, 7, 100. Required: out_valid is high 1 cycle after the 4th accept, with out_ch=2 and out_data=109. The next window for channel 2 starts from 0.
- Back-pressure: len=2, out_ready low, channels 0 and 1 each complete a window. Required:
  - Channel 0's dump is held.
  - Channel 1's second sample is refused (in_ready[1]=0), while channel 1's first sample and channel 0's next first sample are still accepted.
  - After out_ready is pulsed for 1 cycle, channel 1's dump is loaded in that same cycle (pass-through).
- Wrap/saturate: n=16, m=17, len=4, four samples of 32767. Required: out_data = -4 when wrapping; out_data = 65535 when `INTEGRATOR_ARB_SAT_EN` is defined.
- Mid-window reset: channel 0 has accepted 3 of 4 samples, then clr_n is low for 1 cycle. Required: after reset, 4 fresh samples of 1 produce out_data=4, with no contribution from before the reset.

Source files
------------

// File: rtl/integrator_arb_if.sv
// Handshake bundle for integrator_arb: per-channel sample request lanes plus the single dump port.
interface integrator_arb_if #(
   parameter int n  = 16,
   parameter int m  = 24,
   parameter int ch = 4
);
   localparam int chW = (ch > 1) ? $clog2(ch) : 1;

   logic [ch-1:0]   in_valid;
   logic [ch*n-1:0] in_data;
   logic [ch-1:0]   in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [chW-1:0]  out_ch;
   logic [m-1:0]    out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_ch, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_ch, out_data
   );
endinterface

// File: rtl/integrator_arb.sv
// Round-robin integrate-and-dump engine: ch sample streams share one adder and one dump register.
// Optional feature macro INTEGRATOR_ARB_SAT_EN selects saturating accumulation (sticky within a window).
module integrator_arb #(
   parameter int n   = 16,
   parameter int m   = 24,
   parameter int ch  = 4,
   parameter int len = 256
) (
   input  logic             clk,
   input  logic             clr_n,
   integrator_arb_if.slave  io_bus
);

   localparam int cntW = (len > 1) ? $clog2(len) : 1;
   localparam int chW  = (ch > 1) ? $clog2(ch) : 1;
   localparam logic [cntW-1:0] lastCnt = cntW'(len - 1);

   typedef enum logic {OUT_EMPTY, OUT_FULL} outState_t;

   outState_t           r_outState;
   logic signed [m-1:0] r_acc [ch];
   logic [cntW-1:0]     r_cnt [ch];
   logic [chW-1:0]      r_ptr;
   logic [chW-1:0]      r_outCh;
   logic signed [m-1:0] r_outData;

   logic                w_outBlocked;
   logic [ch-1:0]       w_eligible;
   logic                w_grantValid;
   logic [chW-1:0]      w_grantIdx;
   logic                w_final;
   logic signed [n-1:0] w_chSample [ch];
   logic signed [n-1:0] w_rawSample;
   logic signed [m-1:0] w_sample;
   logic signed [m-1:0] w_sum;

   assign w_outBlocked = (r_outState == OUT_FULL) && !io_bus.out_ready;

   // Only a window's closing sample waits on the dump register; everything else flows.
   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < ch; i++) begin
         w_eligible[i] = clr_n && io_bus.in_valid[i] && !((r_cnt[i] == lastCnt) && w_outBlocked);
         w_chSample[i] = io_bus.in_data[i*n +: n];
      end
   end

   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      for (int k = 0; k < ch; k++) begin
         if (!w_grantValid && w_eligible[chW'((int'(r_ptr) + k) % ch)]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = chW'((int'(r_ptr) + k) % ch);
         end
      end
   end

   assign w_rawSample = w_chSample[w_grantIdx];
   assign w_sample    = m'(w_rawSample);
   assign w_final     = w_grantValid && (r_cnt[w_grantIdx] == lastCnt);

`ifdef INTEGRATOR_ARB_SAT_EN
   localparam logic signed [m-1:0] satMax = {1'b0, {(m-1){1'b1}}};
   localparam logic signed [m-1:0] satMin = {1'b1, {(m-1){1'b0}}};

   logic [ch-1:0]     r_sat;
   logic signed [m:0] w_wide;
   logic              w_ovf;

   assign w_wide = {r_acc[w_grantIdx][m-1], r_acc[w_grantIdx]} + {w_sample[m-1], w_sample};
   assign w_ovf  = (w_wide[m] != w_wide[m-1]);

   // Once a window saturates it holds the clamped value until its dump.
   always_comb begin
      if (r_sat[w_grantIdx]) begin
         w_sum = r_acc[w_grantIdx];
      end else if (w_ovf) begin
         w_sum = w_wide[m] ? satMin : satMax;
      end else begin
         w_sum = w_wide[m-1:0];
      end
   end
`else
   assign w_sum = r_acc[w_grantIdx] + w_sample;
`endif

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int i = 0; i < ch; i++) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
         end
         r_ptr      <= '0;
         r_outState <= OUT_EMPTY;
         r_outCh    <= '0;
         r_outData  <= '0;
`ifdef INTEGRATOR_ARB_SAT_EN
         r_sat      <= '0;
`endif
      end else begin
         if ((r_outState == OUT_FULL) && io_bus.out_ready) begin
            r_outState <= OUT_EMPTY;
         end
         if (w_grantValid) begin
            r_ptr <= (w_grantIdx == chW'(ch - 1)) ? '0 : w_grantIdx + 1'b1;
            // A closing sample overrides a same-cycle drain, giving back-to-back dumps.
            if (w_final) begin
               r_outState          <= OUT_FULL;
               r_outCh             <= w_grantIdx;
               r_outData           <= w_sum;
               r_acc[w_grantIdx]   <= '0;
               r_cnt[w_grantIdx]   <= '0;
`ifdef INTEGRATOR_ARB_SAT_EN
               r_sat[w_grantIdx]   <= 1'b0;
`endif
            end else begin
               r_acc[w_grantIdx]   <= w_sum;
               r_cnt[w_grantIdx]   <= r_cnt[w_grantIdx] + 1'b1;
`ifdef INTEGRATOR_ARB_SAT_EN
               r_sat[w_grantIdx]   <= r_sat[w_grantIdx] | w_ovf;
`endif
            end
         end
      end
   end

   // in_ready depends combinationally on out_ready through the blocked-final check.
   assign io_bus.in_ready  = w_grantValid ? (ch'(1) << w_grantIdx) : '0;
   assign io_bus.out_valid = (r_outState == OUT_FULL);
   assign io_bus.out_ch    = r_outCh;
   assign io_bus.out_data  = r_outData;

endmodule

// File: tb/tb_integrator_arb.sv
// Self-checking bench for integrator_arb (ch=4, n=16, m=17, len=4): directed scenarios plus a
// randomized run compared every cycle against a window-level reference model.
module tb_integrator_arb;

   localparam int N   = 16;
   localparam int M   = 17;
   localparam int CH  = 4;
   localparam int LEN = 4;

   logic clk = 1'b0;
   logic clr_n;

   integrator_arb_if #(.n(N), .m(M), .ch(CH)) bus ();

   integrator_arb #(.n(N), .m(M), .ch(CH), .len(LEN)) dut (
      .clk    (clk),
      .clr_n  (clr_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: per-channel running sums and sample counts, one pending dump slot.
   longint mAcc [CH];
   int     mCnt [CH];
   int     mPtr;
   bit     mOutValid;
   int     mOutCh;
   longint mOutData;
   bit     modelLive = 1'b0;
`ifdef INTEGRATOR_ARB_SAT_EN
   bit     mSat [CH];
   localparam longint MAXV = (longint'(1) << (M-1)) - 1;
   localparam longint MINV = -(longint'(1) << (M-1));
`endif

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic longint wrapM(input longint v);
      longint r;
      r = v & ((longint'(1) << M) - 1);
      if (r >= (longint'(1) << (M-1))) r -= (longint'(1) << M);
      return r;
   endfunction

   function automatic longint sampleOf(input int c);
      logic signed [N-1:0] s;
      s = bus.in_data[c*N +: N];
      return longint'(s);
   endfunction

   function automatic logic [CH*N-1:0] oneCh(input int c, input int val);
      logic [CH*N-1:0] r;
      r = '0;
      r[c*N +: N] = N'(val);
      return r;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < CH; i++) begin
         mAcc[i] = 0;
         mCnt[i] = 0;
`ifdef INTEGRATOR_ARB_SAT_EN
         mSat[i] = 1'b0;
`endif
      end
      mPtr      = 0;
      mOutValid = 1'b0;
      mOutCh    = 0;
      mOutData  = 0;
   endtask

   // Checks outputs against the model, then advances the model by the coming clock edge.
   task automatic compareCycle();
      bit              found;
      bit              blocked;
      int              g;
      int              c;
      longint          sum;
      logic [CH-1:0]   expReady;
      found = 1'b0;
      g     = 0;
      if (modelLive) begin
         checkOutput("out_valid", longint'(bus.out_valid), longint'(mOutValid));
         checkOutput("out_ch", longint'(bus.out_ch), longint'(mOutCh));
         checkOutput("out_data", longint'($signed(bus.out_data)), mOutData);
      end
      if (clr_n === 1'b1 && modelLive) begin
         blocked = mOutValid && !bus.out_ready;
         for (int k = 0; k < CH; k++) begin
            c = (mPtr + k) % CH;
            if (!found && bus.in_valid[c] && !(mCnt[c] == LEN-1 && blocked)) begin
               found = 1'b1;
               g     = c;
            end
         end
      end
      expReady = found ? (CH'(1) << g) : '0;
      if (modelLive || clr_n === 1'b0) begin
         checkOutput("in_ready", longint'(bus.in_ready), longint'(expReady));
      end
      if (clr_n === 1'b0) begin
         modelReset();
         modelLive = 1'b1;
      end else if (modelLive) begin
         if (bus.out_ready) mOutValid = 1'b0;
         if (found) begin
`ifdef INTEGRATOR_ARB_SAT_EN
            if (mSat[g]) begin
               sum = mAcc[g];
            end else begin
               sum = mAcc[g] + sampleOf(g);
               if (sum > MAXV) begin sum = MAXV; mSat[g] = 1'b1; end
               else if (sum < MINV) begin sum = MINV; mSat[g] = 1'b1; end
            end
`else
            sum = wrapM(mAcc[g] + sampleOf(g));
`endif
            if (mCnt[g] == LEN-1) begin
               mOutData  = sum;
               mOutCh    = g;
               mOutValid = 1'b1;
               mAcc[g]   = 0;
               mCnt[g]   = 0;
`ifdef INTEGRATOR_ARB_SAT_EN
               mSat[g]   = 1'b0;
`endif
            end else begin
               mAcc[g] = sum;
               mCnt[g] = mCnt[g] + 1;
            end
            mPtr = (g + 1) % CH;
         end
      end
   endtask

   initial begin : compareProc
      forever begin
         @(negedge clk);
         compareCycle();
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [CH-1:0] v, input logic [CH*N-1:0] d, input logic ordy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = ordy;
   endtask

   task automatic expectReady(input string name, input logic [CH-1:0] exp);
      @(negedge clk);
      checkOutput(name, longint'(bus.in_ready), longint'(exp));
      stepCycle();
   endtask

   task automatic expectDump(input string name, input int expCh, input longint expData);
      @(negedge clk);
      checkOutput({name, "_valid"}, longint'(bus.out_valid), 1);
      checkOutput({name, "_ch"}, longint'(bus.out_ch), longint'(expCh));
      checkOutput({name, "_data"}, longint'($signed(bus.out_data)), expData);
      stepCycle();
   endtask

   task automatic doReset();
      clr_n = 1'b0;
      applyStimulus('0, '0, 1'b1);
      stepCycle();
      clr_n = 1'b1;
   endtask

   initial begin : mainProc
      int wSamples [4];
      logic [CH*N-1:0] d;
      logic [N-1:0] v;
      int orBias;

      clr_n = 1'b0;
      applyStimulus('1, '0, 1'b1);

      // Reset held two cycles with every channel requesting.
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         checkOutput("rst_in_ready", longint'(bus.in_ready), 0);
         checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
         checkOutput("rst_out_data", longint'($signed(bus.out_data)), 0);
      end
      clr_n = 1'b1;

      // Round robin with all channels requesting, first grant must be channel 0.
      for (int i = 0; i < 8; i++) begin
         expectReady("rr_all", CH'(1) << (i % 4));
      end
      applyStimulus(4'b1101, '0, 1'b1);
      expectReady("rr_skip1_a", 4'b0001);
      expectReady("rr_skip1_b", 4'b0100);
      expectReady("rr_skip1_c", 4'b1000);
      expectReady("rr_skip1_d", 4'b0001);

      // Window sum on channel 2, then a fresh window from zero.
      doReset();
      wSamples = '{5, -3, 7, 100};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0100, oneCh(2, wSamples[i]), 1'b1);
         expectReady("win_grant", 4'b0100);
      end
      applyStimulus('0, '0, 1'b1);
      expectDump("win1", 2, 109);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0100, oneCh(2, 2), 1'b1);
         expectReady("win2_grant", 4'b0100);
      end
      applyStimulus('0, '0, 1'b1);
      expectDump("win2", 2, 8);

      // Back-pressure: channel 0 dump held, channel 1 closing sample refused.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0001, oneCh(0, 1), 1'b0);
         expectReady("bp_ch0", 4'b0001);
      end
      wSamples = '{10, 20, 30, 40};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0010, oneCh(1, wSamples[i]), 1'b0);
         expectReady("bp_ch1_open", 4'b0010);
      end
      applyStimulus(4'b0010, oneCh(1, 40), 1'b0);
      @(negedge clk);
      checkOutput("bp_ch1_refused", longint'(bus.in_ready), 0);
      checkOutput("bp_held_ch", longint'(bus.out_ch), 0);
      checkOutput("bp_held_data", longint'($signed(bus.out_data)), 4);
      stepCycle();
      applyStimulus(4'b0011, oneCh(0, 7) | oneCh(1, 40), 1'b0);
      expectReady("bp_ch0_next", 4'b0001);
      applyStimulus(4'b0010, oneCh(1, 40), 1'b1);
      expectReady("bp_pass_ready", 4'b0010);
      applyStimulus('0, '0, 1'b0);
      expectDump("bp_ch1", 1, 100);
      expectDump("bp_ch1_stable", 1, 100);
      applyStimulus('0, '0, 1'b1);
      stepCycle();
      @(negedge clk);
      checkOutput("bp_drained", longint'(bus.out_valid), 0);
      stepCycle();

      // Wrap or saturate with four full-scale positive samples.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b1000, oneCh(3, 32767), 1'b1);
         expectReady("wrap_grant", 4'b1000);
      end
      applyStimulus('0, '0, 1'b1);
`ifdef INTEGRATOR_ARB_SAT_EN
      expectDump("sat", 3, 65535);
`else
      expectDump("wrap", 3, -4);
`endif

      // Mid-window reset discards the partial sum.
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0001, oneCh(0, 500), 1'b1);
         expectReady("mid_pre", 4'b0001);
      end
      clr_n = 1'b0;
      stepCycle();
      clr_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0001, oneCh(0, 1), 1'b1);
         expectReady("mid_post", 4'b0001);
      end
      applyStimulus('0, '0, 1'b1);
      expectDump("midrst", 0, 4);

      // Randomized traffic, checked every cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         orBias = (i / 500) % 3;
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 3) == 0) v = N'($urandom);
            else v = N'($urandom_range(0, 40)) - N'(20);
            d[c*N +: N] = v;
         end
         applyStimulus(CH'($urandom), d,
                       (orBias == 0) ? 1'b1 : (orBias == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
         clr_n = ($urandom_range(0, 149) != 0);
         stepCycle();
      end
      clr_n = 1'b1;
      applyStimulus('0, '0, 1'b1);
      repeat (3) stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
